// File: rtl/dhm_pd_seq_if.sv
// ---------------------------------------------------------------------------
// dhm_pd_seq_if
// Bundles the command handshake, the status flags and the power-domain and
// retention-register controls of one dhm_pd_seq instance.
//   cmd_val/cmd_op/cmd_rdy : power-down (op=0) / power-up (op=1) command
//   done/domain_on/busy/err_timeout : sequencer status
//   pd_req/pd_ack/pd_iso/pd_reset_n : power-switch, isolation and reset
//   rreg_stop_req/rreg_stop_ack/rreg_save/rreg_restore : retention control
// master : the sequencer side
// slave  : the command sender plus the power domain
// ---------------------------------------------------------------------------
interface dhm_pd_seq_if;
   logic cmd_val;
   logic cmd_op;
   logic cmd_rdy;
   logic done;
   logic domain_on;
   logic busy;
   logic err_timeout;
   logic pd_req;
   logic pd_ack;
   logic pd_iso;
   logic pd_reset_n;
   logic rreg_stop_req;
   logic rreg_stop_ack;
   logic rreg_save;
   logic rreg_restore;

   modport master (
      input  cmd_val, cmd_op, pd_ack, rreg_stop_ack,
      output cmd_rdy, done, domain_on, busy, err_timeout,
             pd_req, pd_iso, pd_reset_n, rreg_stop_req, rreg_save, rreg_restore
   );

   modport slave (
      output cmd_val, cmd_op, pd_ack, rreg_stop_ack,
      input  cmd_rdy, done, domain_on, busy, err_timeout,
             pd_req, pd_iso, pd_reset_n, rreg_stop_req, rreg_save, rreg_restore
   );
endinterface

// File: rtl/dhm_pd_seq.sv
// ---------------------------------------------------------------------------
// dhm_pd_seq
// Per-domain power sequencer. Accepts power-down / power-up commands and
// walks the domain through stop -> save -> isolate -> reset -> power-off
// (and the reverse for power-up) with fixed settle times. Ack waits are
// bounded; an ack that never arrives locks the block in ERR until reset.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : dhm_pd_seq_if.master (command handshake, status, domain controls)
// Every output is a flop loaded from the decode of the next state, so the
// outputs change on the same edge as the state register.
// ---------------------------------------------------------------------------
module dhm_pd_seq #(
   parameter int SAVE_CYCLES    = 2,
   parameter int RESTORE_CYCLES = 2,
   parameter int ISO_SETTLE     = 4,
   parameter int RST_SETTLE     = 4,
   parameter int ACK_TIMEOUT    = 255,
   parameter int CNT_W          = 8
) (
   input  logic          clk,
   input  logic          reset,
   dhm_pd_seq_if.master  bus
);

   typedef enum logic [3:0] {
      S_ON,
      S_STOP,
      S_SAVE,
      S_ISO,
      S_RST,
      S_PWROFF,
      S_OFF,
      S_PWRON,
      S_RESTORE,
      S_UNRST,
      S_UNISO,
      S_UNSTOP,
      S_ERR
   } state_t;

   // Timed states load N-1 and leave when the counter hits zero (N cycles).
   localparam logic [CNT_W-1:0] SAVE_LD    = CNT_W'(SAVE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RESTORE_LD = CNT_W'(RESTORE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ISO_LD     = CNT_W'(ISO_SETTLE - 1);
   localparam logic [CNT_W-1:0] RST_LD     = CNT_W'(RST_SETTLE - 1);
   // Ack waits count up from zero; reaching this value with no ack is a timeout.
   localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             redundant;
   logic             done_nxt;
   logic             pd_req_nxt, iso_nxt, rst_n_nxt, stop_nxt;

   always_comb begin
      // NOTE: every signal written here gets a default first so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_nxt  = state;
      cnt_nxt    = cnt;
      redundant  = 1'b0;
      pd_req_nxt = bus.pd_req;
      iso_nxt    = bus.pd_iso;
      rst_n_nxt  = bus.pd_reset_n;
      stop_nxt   = bus.rreg_stop_req;

      case (state)
         S_ON: begin
            if (bus.cmd_val) begin
               if (bus.cmd_op) begin
                  redundant = 1'b1;
               end else begin
                  state_nxt = S_STOP;
                  cnt_nxt   = '0;
               end
            end
         end
         S_STOP: begin
            if (bus.rreg_stop_ack) begin
               state_nxt = S_SAVE;
               cnt_nxt   = SAVE_LD;
            end else if (cnt == ACK_LAST) begin
               state_nxt = S_ERR;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_SAVE: begin
            if (cnt == '0) begin
               state_nxt = S_ISO;
               cnt_nxt   = ISO_LD;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_ISO: begin
            if (cnt == '0) begin
               state_nxt = S_RST;
               cnt_nxt   = RST_LD;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_RST: begin
            if (cnt == '0) begin
               state_nxt = S_PWROFF;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_PWROFF: begin
            if (bus.pd_ack) begin
               state_nxt = S_OFF;
            end else if (cnt == ACK_LAST) begin
               state_nxt = S_ERR;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_OFF: begin
            if (bus.cmd_val) begin
               if (!bus.cmd_op) begin
                  redundant = 1'b1;
               end else begin
                  state_nxt = S_PWRON;
                  cnt_nxt   = '0;
               end
            end
         end
         S_PWRON: begin
            if (!bus.pd_ack) begin
               state_nxt = S_RESTORE;
               cnt_nxt   = RESTORE_LD;
            end else if (cnt == ACK_LAST) begin
               state_nxt = S_ERR;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_RESTORE: begin
            if (cnt == '0) begin
               state_nxt = S_UNRST;
               cnt_nxt   = RST_LD;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_UNRST: begin
            if (cnt == '0) begin
               state_nxt = S_UNISO;
               cnt_nxt   = ISO_LD;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_UNISO: begin
            if (cnt == '0) begin
               state_nxt = S_UNSTOP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_UNSTOP: begin
            if (!bus.rreg_stop_ack) begin
               state_nxt = S_ON;
            end else if (cnt == ACK_LAST) begin
               state_nxt = S_ERR;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            // S_ERR: only reset leaves.
            state_nxt = S_ERR;
         end
      endcase

      // Domain controls are a pure function of the position in the sequence;
      // ERR keeps whatever the step before it left (the defaults above).
      case (state_nxt)
         S_ON:      begin pd_req_nxt = 1'b0; iso_nxt = 1'b0; rst_n_nxt = 1'b1; stop_nxt = 1'b0; end
         S_STOP,
         S_SAVE:    begin pd_req_nxt = 1'b0; iso_nxt = 1'b0; rst_n_nxt = 1'b1; stop_nxt = 1'b1; end
         S_ISO:     begin pd_req_nxt = 1'b0; iso_nxt = 1'b1; rst_n_nxt = 1'b1; stop_nxt = 1'b1; end
         S_RST:     begin pd_req_nxt = 1'b0; iso_nxt = 1'b1; rst_n_nxt = 1'b0; stop_nxt = 1'b1; end
         S_PWROFF,
         S_OFF:     begin pd_req_nxt = 1'b1; iso_nxt = 1'b1; rst_n_nxt = 1'b0; stop_nxt = 1'b1; end
         S_PWRON,
         S_RESTORE: begin pd_req_nxt = 1'b0; iso_nxt = 1'b1; rst_n_nxt = 1'b0; stop_nxt = 1'b1; end
         S_UNRST:   begin pd_req_nxt = 1'b0; iso_nxt = 1'b1; rst_n_nxt = 1'b1; stop_nxt = 1'b1; end
         S_UNISO:   begin pd_req_nxt = 1'b0; iso_nxt = 1'b0; rst_n_nxt = 1'b1; stop_nxt = 1'b1; end
         S_UNSTOP:  begin pd_req_nxt = 1'b0; iso_nxt = 1'b0; rst_n_nxt = 1'b1; stop_nxt = 1'b0; end
         default:   ;
      endcase

      done_nxt = redundant
               | ((state == S_PWROFF) && (state_nxt == S_OFF))
               | ((state == S_UNSTOP) && (state_nxt == S_ON));
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= S_ON;
         cnt               <= '0;
         bus.cmd_rdy       <= 1'b1;
         bus.done          <= 1'b0;
         bus.domain_on     <= 1'b1;
         bus.busy          <= 1'b0;
         bus.err_timeout   <= 1'b0;
         bus.pd_req        <= 1'b0;
         bus.pd_iso        <= 1'b0;
         bus.pd_reset_n    <= 1'b1;
         bus.rreg_stop_req <= 1'b0;
         bus.rreg_save     <= 1'b0;
         bus.rreg_restore  <= 1'b0;
      end else begin
         state             <= state_nxt;
         cnt               <= cnt_nxt;
         bus.cmd_rdy       <= (state_nxt == S_ON) || (state_nxt == S_OFF);
         bus.done          <= done_nxt;
         bus.domain_on     <= (state_nxt == S_ON);
         bus.busy          <= !((state_nxt == S_ON) || (state_nxt == S_OFF) || (state_nxt == S_ERR));
         bus.err_timeout   <= (state_nxt == S_ERR);
         bus.pd_req        <= pd_req_nxt;
         bus.pd_iso        <= iso_nxt;
         bus.pd_reset_n    <= rst_n_nxt;
         bus.rreg_stop_req <= stop_nxt;
         bus.rreg_save     <= (state_nxt == S_SAVE);
         bus.rreg_restore  <= (state_nxt == S_RESTORE);
      end
   end

endmodule

// File: tb/tb_dhm_pd_seq.sv
// ---------------------------------------------------------------------------
// tb_dhm_pd_seq
// Self-checking bench for dhm_pd_seq. A table-driven model of the power
// sequence predicts every output each cycle; directed scenarios add literal
// cycle-by-cycle expectations, then a randomized phase exercises commands and
// ack latencies (including timeouts) against the model.
// ---------------------------------------------------------------------------
module tb_dhm_pd_seq;

   localparam int SAVE_N    = 2;
   localparam int RESTORE_N = 2;
   localparam int ISO_N     = 4;
   localparam int RST_N     = 4;
   localparam int TMO       = 16;

   typedef struct packed {
      logic cmd_rdy;
      logic done;
      logic domain_on;
      logic busy;
      logic err_timeout;
      logic pd_req;
      logic pd_iso;
      logic pd_reset_n;
      logic rreg_stop_req;
      logic rreg_save;
      logic rreg_restore;
   } out_t;

   localparam out_t RESET_VEC = 11'b1_0_1_0_0_0_0_1_0_0_0;

   typedef enum {M_ON, M_OFF, M_SEQ, M_ERR} mmode_t;

   logic clk;
   logic reset;
   dhm_pd_seq_if bus();

   dhm_pd_seq #(
      .SAVE_CYCLES(SAVE_N), .RESTORE_CYCLES(RESTORE_N),
      .ISO_SETTLE(ISO_N), .RST_SETTLE(RST_N),
      .ACK_TIMEOUT(TMO), .CNT_W(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check_v(input string name, input out_t act, input out_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_i(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic out_t dut_out();
      out_t o;
      o.cmd_rdy       = bus.cmd_rdy;
      o.done          = bus.done;
      o.domain_on     = bus.domain_on;
      o.busy          = bus.busy;
      o.err_timeout   = bus.err_timeout;
      o.pd_req        = bus.pd_req;
      o.pd_iso        = bus.pd_iso;
      o.pd_reset_n    = bus.pd_reset_n;
      o.rreg_stop_req = bus.rreg_stop_req;
      o.rreg_save     = bus.rreg_save;
      o.rreg_restore  = bus.rreg_restore;
      return o;
   endfunction

   // ---------------- domain responder: acks follow requests -----------------
   int          pd_dly    = 1;
   int          stop_dly  = 1;
   logic        stop_zero = 1'b0;
   logic [31:0] pd_hist   = '0;
   logic [31:0] stop_hist = '0;

   initial begin
      bus.pd_ack        = 1'b0;
      bus.rreg_stop_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pd_hist   = '0;
            stop_hist = '0;
         end else begin
            pd_hist   = {pd_hist[30:0], bus.pd_req};
            stop_hist = {stop_hist[30:0], bus.rreg_stop_req};
         end
         bus.pd_ack        = pd_hist[pd_dly];
         bus.rreg_stop_ack = stop_zero ? 1'b0 : stop_hist[stop_dly];
      end
   end

   // ---------------- behavioural model --------------------------------------
   // The sequence is five steps per direction; steps 0 and 4 wait for an ack,
   // steps 1..3 last a fixed number of cycles. Each step entry sets a few
   // controls, everything else keeps its previous value.
   mmode_t m_mode;
   logic   m_dir;
   int     m_step;
   int     m_cnt;
   logic   m_done, m_pd_req, m_iso, m_rst_n, m_stop, m_save, m_restore;

   function automatic int step_len(input logic dir, input int s);
      if (!dir) return (s == 1) ? SAVE_N : (s == 2) ? ISO_N : RST_N;
      return (s == 1) ? RESTORE_N : (s == 2) ? RST_N : ISO_N;
   endfunction

   function automatic logic ack_met(input logic dir, input int s);
      if (!dir) return (s == 0) ? (bus.rreg_stop_ack == 1'b1) : (bus.pd_ack == 1'b1);
      return (s == 0) ? (bus.pd_ack == 1'b0) : (bus.rreg_stop_ack == 1'b0);
   endfunction

   task automatic model_reset();
      m_mode = M_ON; m_dir = 1'b0; m_step = 0; m_cnt = 0; m_done = 1'b0;
      m_pd_req = 1'b0; m_iso = 1'b0; m_rst_n = 1'b1; m_stop = 1'b0;
      m_save = 1'b0; m_restore = 1'b0;
   endtask

   task automatic model_enter(input int s);
      m_step = s;
      m_cnt  = 0;
      if (!m_dir) begin
         case (s)
            0: m_stop = 1'b1;
            1: m_save = 1'b1;
            2: begin m_save = 1'b0; m_iso = 1'b1; end
            3: m_rst_n = 1'b0;
            default: m_pd_req = 1'b1;
         endcase
      end else begin
         case (s)
            0: m_pd_req = 1'b0;
            1: m_restore = 1'b1;
            2: begin m_restore = 1'b0; m_rst_n = 1'b1; end
            3: m_iso = 1'b0;
            default: m_stop = 1'b0;
         endcase
      end
   endtask

   task automatic model_step();
      int   spent;
      logic adv;
      m_done = 1'b0;
      case (m_mode)
         M_ON, M_OFF: begin
            if (bus.cmd_val) begin
               if (bus.cmd_op == (m_mode == M_ON)) begin
                  m_done = 1'b1;
               end else begin
                  m_dir  = bus.cmd_op;
                  m_mode = M_SEQ;
                  model_enter(0);
               end
            end
         end
         M_SEQ: begin
            spent = m_cnt + 1;
            adv   = 1'b0;
            if (m_step == 0 || m_step == 4) begin
               if (ack_met(m_dir, m_step)) adv = 1'b1;
               else if (spent == TMO) begin
                  m_mode = M_ERR; m_save = 1'b0; m_restore = 1'b0;
               end else m_cnt = spent;
            end else if (spent == step_len(m_dir, m_step)) adv = 1'b1;
            else m_cnt = spent;
            if (adv) begin
               if (m_step == 4) begin
                  m_mode = m_dir ? M_ON : M_OFF;
                  m_done = 1'b1;
               end else model_enter(m_step + 1);
            end
         end
         default: ;
      endcase
   endtask

   function automatic out_t model_out();
      out_t o;
      o.cmd_rdy       = (m_mode == M_ON) || (m_mode == M_OFF);
      o.done          = m_done;
      o.domain_on     = (m_mode == M_ON);
      o.busy          = (m_mode == M_SEQ);
      o.err_timeout   = (m_mode == M_ERR);
      o.pd_req        = m_pd_req;
      o.pd_iso        = m_iso;
      o.pd_reset_n    = m_rst_n;
      o.rreg_stop_req = m_stop;
      o.rreg_save     = m_save;
      o.rreg_restore  = m_restore;
      return o;
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) model_reset();
         else       model_step();
      end
   end

   // ---------------- per-cycle compare against the model -------------------
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) check_v("cycle_outputs", dut_out(), model_out());
      end
   end

   // ---------------- stimulus helpers ---------------------------------------
   out_t snap [0:40];

   // Presents a command until accepted; returns at the negedge of the cycle
   // after acceptance (cycle 1 relative to the accepting cycle 0).
   task automatic send(input logic op);
      int n;
      n = 0;
      @(negedge clk);
      bus.cmd_val = 1'b1;
      bus.cmd_op  = op;
      while (!bus.cmd_rdy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.cmd_rdy) check_b("send_accept_bound", bus.cmd_rdy, 1'b1);
      @(negedge clk);
      bus.cmd_val = 1'b0;
   endtask

   task automatic capture(input int n);
      for (int k = 1; k <= n; k++) begin
         snap[k] = dut_out();
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!bus.cmd_rdy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_b(name, bus.cmd_rdy, 1'b1);
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b1;
      @(negedge clk);
      #1 reset = 1'b0;
   endtask

   // ---------------- main sequence ------------------------------------------
   initial begin
      out_t exp;
      int   done_k, acc_k;
      logic err_seen;

      reset       = 1'b1;
      bus.cmd_val = 1'b0;
      bus.cmd_op  = 1'b0;
      repeat (3) @(negedge clk);
      check_v("reset_values", dut_out(), RESET_VEC);
      #1 reset = 1'b0;

      // Power-down with 1-cycle acks.
      send(1'b0);
      capture(16);
      check_b("down_stop_c1",    snap[1].rreg_stop_req, 1'b1);
      check_b("down_save_c2",    snap[2].rreg_save,     1'b0);
      check_b("down_save_c3",    snap[3].rreg_save,     1'b1);
      check_b("down_save_c4",    snap[4].rreg_save,     1'b1);
      check_b("down_save_c5",    snap[5].rreg_save,     1'b0);
      check_b("down_iso_c4",     snap[4].pd_iso,        1'b0);
      check_b("down_iso_c5",     snap[5].pd_iso,        1'b1);
      check_b("down_rstn_c8",    snap[8].pd_reset_n,    1'b1);
      check_b("down_rstn_c9",    snap[9].pd_reset_n,    1'b0);
      check_b("down_pdreq_c12",  snap[12].pd_req,       1'b0);
      check_b("down_pdreq_c13",  snap[13].pd_req,       1'b1);
      check_b("down_done_c14",   snap[14].done,         1'b0);
      check_b("down_done_c15",   snap[15].done,         1'b1);
      check_b("down_on_c15",     snap[15].domain_on,    1'b0);
      check_b("down_rdy_c15",    snap[15].cmd_rdy,      1'b1);
      check_b("down_done_c16",   snap[16].done,         1'b0);

      // Power-up from OFF.
      send(1'b1);
      capture(16);
      check_b("up_pdreq_c1",     snap[1].pd_req,        1'b0);
      check_b("up_restore_c2",   snap[2].rreg_restore,  1'b0);
      check_b("up_restore_c3",   snap[3].rreg_restore,  1'b1);
      check_b("up_restore_c4",   snap[4].rreg_restore,  1'b1);
      check_b("up_rstn_c4",      snap[4].pd_reset_n,    1'b0);
      check_b("up_rstn_c5",      snap[5].pd_reset_n,    1'b1);
      check_b("up_iso_c8",       snap[8].pd_iso,        1'b1);
      check_b("up_iso_c9",       snap[9].pd_iso,        1'b0);
      check_b("up_stop_c12",     snap[12].rreg_stop_req, 1'b1);
      check_b("up_stop_c13",     snap[13].rreg_stop_req, 1'b0);
      check_b("up_done_c15",     snap[15].done,         1'b1);
      check_b("up_on_c15",       snap[15].domain_on,    1'b1);

      // Redundant power-up while ON.
      send(1'b1);
      capture(2);
      exp      = RESET_VEC;
      exp.done = 1'b1;
      check_v("redundant_c1", snap[1], exp);
      check_v("redundant_c2", snap[2], RESET_VEC);

      // Asynchronous reset while in ISO, then a clean power-down.
      send(1'b0);
      begin
         int n;
         n = 0;
         while (!bus.pd_iso && n < 40) begin
            @(negedge clk);
            n++;
         end
         check_b("reach_iso", bus.pd_iso, 1'b1);
      end
      #2 reset = 1'b1;
      #1 check_v("async_reset_in_iso", dut_out(), RESET_VEC);
      @(negedge clk);
      #1 reset = 1'b0;
      send(1'b0);
      wait_idle("down_after_reset_idle");
      check_b("down_after_reset_off", bus.domain_on, 1'b0);
      check_b("down_after_reset_pdreq", bus.pd_req, 1'b1);

      // Back to ON, then slow pd_ack with a command held during the transition.
      send(1'b1);
      wait_idle("up_before_slow_idle");
      pd_dly = 10;
      send(1'b0);
      bus.cmd_val = 1'b1;
      bus.cmd_op  = 1'b1;
      done_k   = -1;
      acc_k    = -1;
      err_seen = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (acc_k >= 0 && k > acc_k) bus.cmd_val = 1'b0;
         if (bus.err_timeout) err_seen = 1'b1;
         if (k == 18) check_b("slow_pdreq_held", bus.pd_req, 1'b1);
         if (bus.done && done_k < 0) done_k = k;
         if (bus.cmd_rdy && bus.cmd_val && acc_k < 0) acc_k = k;
         @(negedge clk);
      end
      bus.cmd_val = 1'b0;
      check_i("slow_done_cycle", done_k, 24);
      check_i("slow_accept_cycle", acc_k, 24);
      check_b("slow_no_timeout", err_seen, 1'b0);
      wait_idle("slow_up_idle");
      check_b("slow_up_on", bus.domain_on, 1'b1);
      pd_dly = 1;

      // Timeout: stop ack never arrives.
      stop_zero = 1'b1;
      send(1'b0);
      capture(18);
      check_b("tmo_busy_c16",  snap[16].busy,          1'b1);
      check_b("tmo_err_c16",   snap[16].err_timeout,   1'b0);
      check_b("tmo_err_c17",   snap[17].err_timeout,   1'b1);
      check_b("tmo_rdy_c17",   snap[17].cmd_rdy,       1'b0);
      check_b("tmo_busy_c17",  snap[17].busy,          1'b0);
      check_b("tmo_stop_c17",  snap[17].rreg_stop_req, 1'b1);
      bus.cmd_val = 1'b1;
      bus.cmd_op  = 1'b1;
      repeat (6) @(negedge clk);
      check_b("tmo_ignores_cmd", bus.err_timeout, 1'b1);
      bus.cmd_val = 1'b0;
      stop_zero   = 1'b0;
      pulse_reset();
      check_v("tmo_cleared_by_reset", dut_out(), RESET_VEC);

      // Randomized commands and ack latencies, checked by the model.
      for (int i = 0; i < 3000; i++) begin
         if (i % 64 == 0) begin
            pd_dly   = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 6));
            stop_dly = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 6));
         end
         if (bus.err_timeout && ($urandom_range(0, 3) == 0)) begin
            bus.cmd_val = 1'b0;
            pulse_reset();
         end else begin
            bus.cmd_val = ($urandom_range(0, 3) == 0);
            bus.cmd_op  = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
      end
      bus.cmd_val = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
